// File: rtl/dmd_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : dmd_scanner
//  Purpose  : Dot-matrix display scan controller with a double-buffered,
//             flop-based frame store. CPU writes land in the back bank; a
//             swap request is applied only at the frame boundary (row 0
//             latch) so a frame is never torn.
//  Options  : DMD_SCANNER_DIM_EN - adds the 2-bit `dim` input that shortens
//             the lit part of every SHOW period to DWELL*(4-dim)/4 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module dmd_scanner #(
  parameter int COLS     = 16,
  parameter int ROW_BITS = 4,
  parameter int DWELL    = 1024,
  parameter int BLANK    = 8
) (
  input  logic                CLK,
  input  logic                RESET,
`ifdef DMD_SCANNER_DIM_EN
  input  logic [1:0]          dim,
`endif
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] wr_row,
  input  logic [COLS-1:0]     wr_data,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                frame_start,
  output logic [ROW_BITS-1:0] dmd_seg,
  output logic [COLS-1:0]     dmd_column,
  output logic                DMD_CLR,
  output logic                DMD_CLK
);

  localparam int ROWS    = 1 << ROW_BITS;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);

  localparam logic [1:0] c_st_blank = 2'd0;
  localparam logic [1:0] c_st_latch = 2'd1;
  localparam logic [1:0] c_st_show  = 2'd2;

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ROW_BITS-1:0] r_next_row;
  logic                r_bank_sel;
  logic                r_pending;
  logic [COLS-1:0]     r_mem [2][ROWS];

  logic                r_swap_ack;
  logic                r_frame_start;
  logic [ROW_BITS-1:0] r_seg;
  logic [COLS-1:0]     r_column;
  logic                r_clr;
  logic                r_dmd_clk;

  // A swap is taken when the row about to be latched is row 0 and a request
  // is either pending or arriving right now; row 0 then reads the new front.
  logic                w_swap;
  logic                w_front_sel;
  logic [COLS-1:0]     w_front_row;

  assign w_swap      = (r_next_row == '0) && (r_pending || swap_req);
  assign w_front_sel = w_swap ? ~r_bank_sel : r_bank_sel;
  assign w_front_row = r_mem[w_front_sel][r_next_row];

`ifdef DMD_SCANNER_DIM_EN
  localparam int QTR = DWELL / 4;

  logic [1:0]       r_dim;
  logic [CNT_W-1:0] w_on_lim;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Number of lit SHOW cycles for the brightness level captured at LATCH.
  always_comb begin
    w_on_lim = CNT_W'(DWELL);
    case (r_dim)
      2'd1:    w_on_lim = CNT_W'(3 * QTR);
      2'd2:    w_on_lim = CNT_W'(2 * QTR);
      2'd3:    w_on_lim = CNT_W'(QTR);
      default: w_on_lim = CNT_W'(DWELL);
    endcase
  end

  assign w_cnt_nxt = r_cnt + 1'b1;
`endif

  // Scan FSM, frame store, swap handshake and registered driver outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= c_st_blank;
      r_cnt         <= '0;
      r_next_row    <= '0;
      r_bank_sel    <= 1'b0;
      r_pending     <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      r_seg         <= '0;
      r_column      <= '0;
      r_clr         <= 1'b1;
      r_dmd_clk     <= 1'b0;
`ifdef DMD_SCANNER_DIM_EN
      r_dim         <= 2'd0;
`endif
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          r_mem[b][r] <= '0;
        end
      end
    end else begin
      r_swap_ack    <= 1'b0;
      r_frame_start <= 1'b0;
      r_pending     <= r_pending | swap_req;

      // Back bank is selected by the pre-edge bank_sel, so a write in the
      // swap cycle lands in the bank that is becoming front.
      if (wr_en) begin
        r_mem[~r_bank_sel][wr_row] <= wr_data;
      end

      case (r_state)
        c_st_blank: begin
          if (r_cnt == c_blank_last) begin
            r_state    <= c_st_latch;
            r_cnt      <= '0;
            r_seg      <= r_next_row;
            r_column   <= w_front_row;
            r_dmd_clk  <= 1'b1;
            r_next_row <= r_next_row + 1'b1;
            if (r_next_row == '0) begin
              r_frame_start <= 1'b1;
              if (w_swap) begin
                r_bank_sel <= ~r_bank_sel;
                r_pending  <= 1'b0;
                r_swap_ack <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_st_latch: begin
          // First SHOW cycle is always lit: even dim=3 keeps DWELL/4 >= 1.
          r_state   <= c_st_show;
          r_cnt     <= '0;
          r_dmd_clk <= 1'b0;
          r_clr     <= 1'b0;
`ifdef DMD_SCANNER_DIM_EN
          r_dim     <= dim;
`endif
        end

        c_st_show: begin
          if (r_cnt == c_dwell_last) begin
            r_state  <= c_st_blank;
            r_cnt    <= '0;
            r_clr    <= 1'b1;
            r_column <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`ifdef DMD_SCANNER_DIM_EN
            // Once the lit window is used up, blank for the rest of the row.
            if (!(w_cnt_nxt < w_on_lim)) begin
              r_clr    <= 1'b1;
              r_column <= '0;
            end
`endif
          end
        end

        default: begin
          r_state   <= c_st_blank;
          r_cnt     <= '0;
          r_clr     <= 1'b1;
          r_column  <= '0;
          r_dmd_clk <= 1'b0;
        end
      endcase
    end
  end

  assign swap_ack    = r_swap_ack;
  assign frame_start = r_frame_start;
  assign dmd_seg     = r_seg;
  assign dmd_column  = r_column;
  assign DMD_CLR     = r_clr;
  assign DMD_CLK     = r_dmd_clk;

endmodule
`default_nettype wire

// File: tb/tb_dmd_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dmd_scanner
//  Purpose  : Self-checking bench for dmd_scanner (COLS=8, ROW_BITS=2,
//             DWELL=8, BLANK=2). A time-indexed behavioural model predicts
//             every output each cycle; directed phases pin the model with
//             hand-computed values; a random phase stresses writes/swaps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmd_scanner;

  localparam int COLS     = 8;
  localparam int ROW_BITS = 2;
  localparam int DWELL    = 8;
  localparam int BLANK    = 2;
  localparam int ROWS     = 4;
  localparam int P        = BLANK + 1 + DWELL;
  localparam int FRAME    = ROWS * P;

  logic                CLK = 1'b0;
  logic                RESET = 1'b1;
  logic                wr_en = 1'b0;
  logic [ROW_BITS-1:0] wr_row = '0;
  logic [COLS-1:0]     wr_data = '0;
  logic                swap_req = 1'b0;
`ifdef DMD_SCANNER_DIM_EN
  logic [1:0]          dim = 2'd0;
`endif
  logic                swap_ack;
  logic                frame_start;
  logic [ROW_BITS-1:0] dmd_seg;
  logic [COLS-1:0]     dmd_column;
  logic                DMD_CLR;
  logic                DMD_CLK;

  always #5 CLK = ~CLK;

  dmd_scanner #(
    .COLS(COLS), .ROW_BITS(ROW_BITS), .DWELL(DWELL), .BLANK(BLANK)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
`ifdef DMD_SCANNER_DIM_EN
    .dim(dim),
`endif
    .wr_en(wr_en),
    .wr_row(wr_row),
    .wr_data(wr_data),
    .swap_req(swap_req),
    .swap_ack(swap_ack),
    .frame_start(frame_start),
    .dmd_seg(dmd_seg),
    .dmd_column(dmd_column),
    .DMD_CLR(DMD_CLR),
    .DMD_CLK(DMD_CLK)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state: cycle index since reset, banks, selection and latched row.
  int              m_n = 0;
  int              cyc = 0;
  bit              m_sel = 1'b0;
  bit              m_pend = 1'b0;
  logic [COLS-1:0] m_bank [2][ROWS];
  logic [COLS-1:0] m_lat = '0;
  int              m_row = 0;
  int              m_dim = 0;

  logic [ROW_BITS-1:0] e_seg = '0;
  logic [COLS-1:0]     e_col = '0;
  logic                e_clr = 1'b1;
  logic                e_clk = 1'b0;
  logic                e_ack = 1'b0;
  logic                e_fs  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: the position inside the row period is m_n mod P,
  // the row slot is (m_n / P) mod ROWS; outputs follow from that position.
  always @(posedge CLK) begin : p_model
    int q;
    int slot;
    bit wsel;
    bit sw;
    bit on;
    if (RESET) begin
      m_n = 0; cyc = 1; m_sel = 0; m_pend = 0; m_lat = '0; m_row = 0; m_dim = 0;
      for (int b = 0; b < 2; b++) for (int r = 0; r < ROWS; r++) m_bank[b][r] = '0;
      e_ack = 0; e_fs = 0;
    end else begin
      q = m_n % P;
      slot = (m_n / P) % ROWS;
      wsel = m_sel;
      e_ack = 0; e_fs = 0;
      if (q == BLANK - 1) begin
        sw = (slot == 0) && (m_pend || swap_req);
        if (slot == 0) e_fs = 1;
        if (sw) begin
          m_sel = ~m_sel; m_pend = 0; e_ack = 1;
        end else begin
          m_pend = m_pend | swap_req;
        end
        m_row = slot;
        m_lat = m_bank[m_sel][slot];
      end else begin
        m_pend = m_pend | swap_req;
      end
`ifdef DMD_SCANNER_DIM_EN
      if (q == BLANK) m_dim = int'(dim);
`endif
      if (wr_en) m_bank[~wsel][wr_row] = wr_data;
      m_n++;
      cyc++;
    end
    q = m_n % P;
    on = (q == BLANK) || ((q > BLANK) && ((q - BLANK - 1) < (DWELL / 4) * (4 - m_dim)));
    e_clk = (q == BLANK);
    e_col = (q >= BLANK && on) ? m_lat : '0;
    e_clr = !((q > BLANK) && on);
    e_seg = ROW_BITS'(m_row);
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("seg", dmd_seg, e_seg);
      check("column", dmd_column, e_col);
      check("clr", DMD_CLR, e_clr);
      check("dmd_clk", DMD_CLK, e_clk);
      check("swap_ack", swap_ack, e_ack);
      check("frame_start", frame_start, e_fs);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  int              exp_clk [5] = '{3, 14, 25, 36, 47};
  int              exp_seg [5] = '{0, 1, 2, 3, 0};
  int              exp_fs  [2] = '{3, 47};
  logic [COLS-1:0] pat     [4] = '{8'h81, 8'h42, 8'h24, 8'h18};

  initial begin : p_main
    int clkc[$];
    int segc[$];
    int fsc[$];
    int nz;
    int acks;
    logic [COLS-1:0] ack_col;
    int first_clk;

    RESET = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    RESET = 1'b0;

    // Reset state during cycle 1.
    check("rst_clr", DMD_CLR, 1'b1);
    check("rst_clk", DMD_CLK, 1'b0);
    check("rst_seg", dmd_seg, 0);
    check("rst_col", dmd_column, 0);

    // Idle scan after reset: strobes, row order, frame pulses.
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      if (DMD_CLK) begin clkc.push_back(cyc); segc.push_back(int'(dmd_seg)); end
      if (frame_start) fsc.push_back(cyc);
      if (dmd_column != 0) nz++;
      step();
    end
    check("idle_clk_count", clkc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("idle_clk_cycle", (i < clkc.size()) ? clkc[i] : -1, exp_clk[i]);
      check("idle_seg", (i < segc.size()) ? segc[i] : -1, exp_seg[i]);
    end
    check("idle_fs_count", fsc.size(), 2);
    for (int i = 0; i < 2; i++) check("idle_fs_cycle", (i < fsc.size()) ? fsc[i] : -1, exp_fs[i]);
    check("idle_col_nonzero", nz, 0);

    // Fill the back bank and request one swap.
    for (int r = 0; r < 4; r++) begin
      wr_en = 1'b1; wr_row = ROW_BITS'(r); wr_data = pat[r];
      step();
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    nz = 0;
    for (int i = 0; i < FRAME + 5 && !swap_ack; i++) begin
      if (dmd_column != 0) nz++;
      step();
    end
    check("p2_pre_swap_dark", nz, 0);
    check("p2_ack", swap_ack, 1'b1);
    check("p2_fs_with_ack", frame_start, 1'b1);
    check("p2_ack_cycle", cyc, 91);
    check("p2_row0", dmd_column, 8'h81);
    for (int r = 1; r < 4; r++) begin
      repeat (P) step();
      check("p2_clk", DMD_CLK, 1'b1);
      check("p2_seg", dmd_seg, r);
      check("p2_col", dmd_column, pat[r]);
    end

    // Three requests inside one frame collapse into a single swap.
    for (int i = 0; i < FRAME + 2 && !frame_start; i++) step();
    check("p3_fs_seen", frame_start, 1'b1);
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      swap_req = 1'b1; step(); swap_req = 1'b0;
      repeat (4) step();
    end
    acks = 0;
    ack_col = 8'hEE;
    for (int i = 0; i < 60; i++) begin
      if (swap_ack) begin acks++; ack_col = dmd_column; end
      step();
    end
    check("p3_one_ack", acks, 1);
    check("p3_front_back_to_zero", ack_col, 8'h00);

    // Swap request plus a write to row 2 in the boundary cycle.
    for (int i = 0; i < FRAME && (cyc % FRAME) != 2; i++) step();
    swap_req = 1'b1; wr_en = 1'b1; wr_row = 2'd2; wr_data = 8'hFF;
    step();
    swap_req = 1'b0; wr_en = 1'b0;
    check("p4_ack", swap_ack, 1'b1);
    check("p4_fs", frame_start, 1'b1);
    check("p4_row0", dmd_column, 8'h81);
    repeat (2 * P) step();
    check("p4_row2_clk", DMD_CLK, 1'b1);
    check("p4_row2_seg", dmd_seg, 2);
    check("p4_row2_ff", dmd_column, 8'hFF);

    // Pending swap, then reset in the middle of row 2 SHOW.
    swap_req = 1'b1; step(); swap_req = 1'b0;
    repeat (2) step();
    check("p5_in_show", DMD_CLR, 1'b0);
    RESET = 1'b1;
    step();
    check("p5_rst_clr", DMD_CLR, 1'b1);
    check("p5_rst_col", dmd_column, 0);
    check("p5_rst_seg", dmd_seg, 0);
    check("p5_rst_clk", DMD_CLK, 1'b0);
    RESET = 1'b0;
    acks = 0;
    first_clk = -1;
    for (int i = 0; i < 50; i++) begin
      if (swap_ack) acks++;
      if (DMD_CLK && first_clk < 0) first_clk = cyc;
      step();
    end
    check("p5_pending_lost", acks, 0);
    check("p5_first_clk", first_clk, 3);

`ifdef DMD_SCANNER_DIM_EN
    // dim=2: half of each SHOW is lit.
    dim = 2'd2;
    for (int i = 0; i < P + 2 && !DMD_CLK; i++) step();
    check("dim_latch_seen", DMD_CLK, 1'b1);
    step();
    nz = 0;
    for (int i = 0; i < DWELL; i++) begin
      if (!DMD_CLR) nz++;
      step();
    end
    check("dim2_lit_cycles", nz, 4);
    dim = 2'd0;
`endif

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom % 3) == 0;
      wr_row   = ROW_BITS'($urandom);
      wr_data  = COLS'($urandom);
      swap_req = ($urandom % 40) == 0;
      RESET    = ($urandom % 700) == 0;
`ifdef DMD_SCANNER_DIM_EN
      dim      = 2'($urandom);
`endif
      step();
    end
    wr_en = 1'b0; swap_req = 1'b0; RESET = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmd_scanner.md
# dmd_scanner

Parametrised dot-matrix display scan controller with a double-buffered frame store. The CPU side writes rows into a back buffer and requests a swap, which is applied only at a frame boundary so no frame is ever torn. The scan side drives the row select (`dmd_seg`), the column data (`dmd_column`) and the driver strobes (`DMD_CLR`, `DMD_CLK`) of the board's LED matrix. It generalises the fixed 16-column, 16-row display path in size, timing and brightness.

## Interface
- `COLS`, default 16: columns per row, i.e. the width of `dmd_column`.
- `ROW_BITS`, default 4: row index width; ROWS = 2^ROW_BITS.
- `DWELL`, default 1024: SHOW cycles per row; must be ≥ 4 and a multiple of 4.
- `BLANK`, default 8: blanking cycles before each row; must be ≥ 1.

- `CLK` in 1: the single clock; all logic is on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe into the back buffer.
- `wr_row` in ROW_BITS: row address to write.
- `wr_data` in COLS: row pixel data; bit i drives column i, 1 = lit.
- `swap_req` in 1: one-cycle swap request.
- `swap_ack` out 1: one-cycle pulse when a swap is applied.
- `frame_start` out 1: one-cycle pulse when row 0 is latched.
- `dmd_seg` out ROW_BITS: selected row.
- `dmd_column` out COLS: column drive data.
- `DMD_CLR` out 1: driver clear/blank, active-high.
- `DMD_CLK` out 1: one-cycle driver latch strobe.

## Operation
- Two flop-based banks, each ROWS×COLS. `bank_sel` chooses the front bank; the back bank is `!bank_sel`.
- Writes: when `wr_en`=1, `back[wr_row]` ← `wr_data` at the edge. The bank is chosen by the pre-edge `bank_sel`.
- Swap: `swap_req`=1 sets a sticky `pending` flag. Several requests before a boundary collapse into one swap.
- FSM states:
  - BLANK: `DMD_CLR`=1, `dmd_column`=0. Lasts BLANK cycles, then goes to LATCH.
  - LATCH: lasts 1 cycle; goes to SHOW.
  - SHOW: lasts DWELL cycles; goes back to BLANK.
- On the BLANK→LATCH edge:
  - `dmd_seg` ← `next_row`.
  - `dmd_column` ← `front[next_row]`.
  - `DMD_CLK` ← 1.
  - `next_row` ← `next_row`+1, wrapping from ROWS-1 to 0.
- Frame boundary: when `next_row`=0 at the BLANK→LATCH edge:
  - `frame_start` pulses.
  - If `pending` is set, or `swap_req`=1 in that cycle: toggle `bank_sel` first, so row 0 reads the new front bank; clear `pending`; `swap_ack` pulses with `frame_start`.
- LATCH: `DMD_CLR`=1 and `DMD_CLK`=1.
- SHOW: `DMD_CLR`=0 and `DMD_CLK`=0. `dmd_column` holds the latched row and does not follow writes made during the row.
- All outputs are registered.
- Reset values:
  - Outputs: `dmd_seg`=0, `dmd_column`=0, `DMD_CLR`=1, `DMD_CLK`=0, `swap_ack`=0, `frame_start`=0.
  - Internal: state = BLANK with its counter at 0, `next_row`=0, `bank_sel`=0, `pending`=0, both banks all zero.
- Reset mid-frame returns everything to the reset values at the next edge. A pending swap is discarded.

## Timing
- Row period = BLANK+1+DWELL cycles. Frame period = ROWS×(BLANK+1+DWELL) cycles.
- After `RESET` falls, the first `DMD_CLK` is high during cycle BLANK+1, counting from the first non-reset cycle as cycle 1.
- Write-to-display latency: the data is shown from the first frame after the next applied swap.
- A write issued in the swap cycle lands in the bank that becomes front, and appears in that frame unless its row is 0. Row 0 was latched that same cycle.

## Configuration
- `DMD_SCANNER_DIM_EN` defined:
  - Adds input `dim` [1:0].
  - During SHOW, columns are driven only for the first DWELL×(4−`dim`)/4 cycles.
  - For the remaining cycles, `dmd_column`=0 and `DMD_CLR`=1.
  - `dim` is sampled on the LATCH cycle.
  - `dim`=0 gives full brightness.
- Undefined: no `dim` port; every SHOW cycle drives full brightness.

## Test plan
Bench parameters: COLS=8, ROW_BITS=2, DWELL=8, BLANK=2. Row period is 11 cycles; frame period is 44.

- Reset, no writes:
  - `DMD_CLK` pulses at cycles 3, 14, 25, 36, 47.
  - `dmd_seg` steps 0,1,2,3,0.
  - `dmd_column`=0 throughout.
  - `frame_start` pulses at cycles 3 and 47.
- Write rows 0..3 = 8'h81, 8'h42, 8'h24, 8'h18, then one `swap_req`:
  - Display stays 0 until the next boundary.
  - At that boundary `swap_ack` and `frame_start` pulse together.
  - Rows then show 81, 42, 24, 18.
- Three `swap_req` pulses within one frame: exactly one `swap_ack`, and `bank_sel` toggles once.
- `swap_req` and `wr_en` (row 2, 8'hFF) in the boundary cycle:
  - The swap is applied.
  - Row 2 of the same frame shows FF.
- Assert `RESET` during SHOW of row 2: on the next edge, `DMD_CLR`=1, `dmd_column`=0, `dmd_seg`=0, and the pending swap is lost.
- With `DMD_SCANNER_DIM_EN` defined and `dim`=2: each SHOW drives data for 4 cycles, then holds `DMD_CLR`=1 and `dmd_column`=0 for 4 cycles.
